// File: rtl/data_package_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : data_package_pkg
// Purpose  : Shared definitions for the frame packer and unpacker: default
//            data/address widths and the unpacker FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package data_package_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 7;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RX_HI    = 3'd1,
      ST_RX_LO    = 3'd2,
      ST_DISCARD  = 3'd3,
      ST_DRAIN_HI = 3'd4,
      ST_DRAIN_LO = 3'd5
   } unpack_state_t;

endpackage
`default_nettype wire

// File: rtl/data_unpackage_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : data_unpackage_if
// Purpose  : Frame input stream plus the high-type and low-type output
//            streams of the unpacker, all valid/ready handshaked.
// Ports    : in_vld/in_data/in_last/in_rdy  - frame input stream
//            hi_vld/hi_data/hi_rdy          - high-type output stream
//            lo_vld/lo_data/lo_rdy          - low-type output stream
//            master modport = stream source/sink, slave modport = unpacker
// Revision : 1.0 - initial release
// ============================================================================
interface data_unpackage_if
   import data_package_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

   logic                  in_vld;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  in_rdy;
   logic                  hi_vld;
   logic [DATA_WIDTH-1:0] hi_data;
   logic                  hi_rdy;
   logic                  lo_vld;
   logic [DATA_WIDTH-1:0] lo_data;
   logic                  lo_rdy;

   modport master (
      output in_vld, in_data, in_last, hi_rdy, lo_rdy,
      input  in_rdy, hi_vld, hi_data, lo_vld, lo_data
   );

   modport slave (
      input  in_vld, in_data, in_last, hi_rdy, lo_rdy,
      output in_rdy, hi_vld, hi_data, lo_vld, lo_data
   );

endinterface
`default_nettype wire

// File: rtl/simple_dual_port_ram_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : simple_dual_port_ram_sync
// Purpose  : One write port, one read port, single clock. Read data is
//            registered (1-cycle latency) and holds its value while rd_en=0.
// Ports    : clk                      - clock
//            wr_en/wr_addr/wr_data    - write port
//            rd_en/rd_addr/rd_data    - read port
// Revision : 1.0 - initial release
// ============================================================================
module simple_dual_port_ram_sync #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 7
) (
   input  wire logic                  clk,
   input  wire logic                  wr_en,
   input  wire logic [ADDR_WIDTH-1:0] wr_addr,
   input  wire logic [DATA_WIDTH-1:0] wr_data,
   input  wire logic                  rd_en,
   input  wire logic [ADDR_WIDTH-1:0] rd_addr,
   output logic      [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (wr_en) r_mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= r_mem[rd_addr];
   end

endmodule
`default_nettype wire

// File: rtl/data_unpackage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : data_unpackage
// Purpose  : Buffers a whole frame (header H, H high words, L low words),
//            then replays the high words on the hi stream and the low words
//            on the lo stream, both in arrival order. High words fill the
//            buffer from the top down, low words from the bottom up.
// Ports    : clk, rst_n (async, active-low)
//            bus          - data_unpackage_if.slave (in / hi / lo streams)
//            pkg_num      - H+L of the last accepted frame
//            pkg_num_vld  - one-cycle pulse qualifying pkg_num
//            err          - one-cycle pulse when a frame is rejected
// Revision : 1.0 - initial release
// ============================================================================
module data_unpackage
   import data_package_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   data_unpackage_if.slave    bus,
   output logic [ADDR_WIDTH:0] pkg_num,
   output logic               pkg_num_vld,
   output logic               err
);

   localparam logic [ADDR_WIDTH:0] CAP_W = {1'b1, {ADDR_WIDTH{1'b0}}};

   unpack_state_t           r_state, w_state_nxt;
   logic                    r_run;
   logic [ADDR_WIDTH-1:0]   r_hi_num, r_hi_cnt;
   logic [ADDR_WIDTH:0]     r_lo_cnt, r_rd_cnt, r_hs_cnt;
   logic                    r_s1, r_s2;           // RAM output / output register occupied
   logic [DATA_WIDTH-1:0]   r_out_data;
   logic [ADDR_WIDTH:0]     r_pkg_num;
   logic                    r_pkg_num_vld, r_err;

   logic                    w_in_rdy, w_in_fire, w_drain, w_hs, w_out_load, w_hi_final;
   logic [ADDR_WIDTH-1:0]   w_hdr_h, w_lo_idx, w_rd_addr, w_wr_addr;
   logic [ADDR_WIDTH:0]     w_total, w_pkg_num;
   logic                    w_wr_en, w_rd_en, w_err, w_pkg_vld;
   logic [DATA_WIDTH-1:0]   w_rd_data;

   assign w_drain    = (r_state == ST_DRAIN_HI) || (r_state == ST_DRAIN_LO);
   assign w_in_rdy   = r_run && !w_drain;
   assign w_in_fire  = bus.in_vld && w_in_rdy;
   assign w_hdr_h    = bus.in_data[ADDR_WIDTH-1:0];
   assign w_total    = {1'b0, r_hi_num} + r_lo_cnt;
   assign w_hi_final = (r_hi_cnt == r_hi_num - 1'b1);

   // Drain walks a single index 0..H+L-1 across both states so the first
   // low word is prefetched while the last high word is still presented.
   assign w_hs       = r_s2 && (((r_state == ST_DRAIN_HI) && bus.hi_rdy) ||
                                ((r_state == ST_DRAIN_LO) && bus.lo_rdy));
   assign w_out_load = r_s1 && (!r_s2 || w_hs);
   assign w_rd_en    = w_drain && (r_rd_cnt != w_total) && (!r_s1 || w_out_load);
   assign w_lo_idx   = r_rd_cnt[ADDR_WIDTH-1:0] - r_hi_num;
   assign w_rd_addr  = (r_rd_cnt < {1'b0, r_hi_num}) ? ~r_rd_cnt[ADDR_WIDTH-1:0] : w_lo_idx;

   always_comb begin
      w_state_nxt = r_state;
      w_wr_en     = 1'b0;
      w_wr_addr   = r_lo_cnt[ADDR_WIDTH-1:0];
      w_err       = 1'b0;
      w_pkg_vld   = 1'b0;
      w_pkg_num   = w_total;
      case (r_state)
         ST_IDLE: if (w_in_fire) begin
            if (bus.in_last) begin
               if (w_hdr_h == '0) begin
                  w_pkg_vld = 1'b1;
                  w_pkg_num = '0;
               end else begin
                  w_err = 1'b1;
               end
            end else begin
               w_state_nxt = (w_hdr_h != '0) ? ST_RX_HI : ST_RX_LO;
            end
         end
         ST_RX_HI: if (w_in_fire) begin
            if (bus.in_last && !w_hi_final) begin
               w_err       = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_wr_en   = 1'b1;
               w_wr_addr = ~r_hi_cnt;               // CAP-1-k
               if (w_hi_final) begin
                  w_state_nxt = bus.in_last ? ST_DRAIN_HI : ST_RX_LO;
                  w_pkg_vld   = bus.in_last;
               end
            end
         end
         ST_RX_LO: if (w_in_fire) begin
            if (w_total == CAP_W) begin
               w_err       = 1'b1;
               w_state_nxt = bus.in_last ? ST_IDLE : ST_DISCARD;
            end else begin
               w_wr_en = 1'b1;
               if (bus.in_last) begin
                  w_pkg_vld   = 1'b1;
                  w_pkg_num   = w_total + 1'b1;
                  w_state_nxt = (r_hi_num != '0) ? ST_DRAIN_HI : ST_DRAIN_LO;
               end
            end
         end
         ST_DISCARD: if (w_in_fire && bus.in_last) w_state_nxt = ST_IDLE;
         ST_DRAIN_HI: begin
            if (w_hs && (r_hs_cnt == w_total - 1'b1))
               w_state_nxt = ST_IDLE;
            else if (w_hs && (r_hs_cnt == {1'b0, r_hi_num} - 1'b1))
               w_state_nxt = ST_DRAIN_LO;
         end
         ST_DRAIN_LO: if (w_hs && (r_hs_cnt == w_total - 1'b1)) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_run         <= 1'b0;
         r_hi_num      <= '0;
         r_hi_cnt      <= '0;
         r_lo_cnt      <= '0;
         r_rd_cnt      <= '0;
         r_hs_cnt      <= '0;
         r_s1          <= 1'b0;
         r_s2          <= 1'b0;
         r_out_data    <= '0;
         r_pkg_num     <= '0;
         r_pkg_num_vld <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_run         <= 1'b1;
         r_err         <= w_err;
         r_pkg_num_vld <= w_pkg_vld;
         if (w_pkg_vld) r_pkg_num <= w_pkg_num;

         if ((r_state == ST_IDLE) && w_in_fire) begin
            r_hi_num <= w_hdr_h;
            r_hi_cnt <= '0;
            r_lo_cnt <= '0;
         end else if (w_wr_en && (r_state == ST_RX_HI)) begin
            r_hi_cnt <= r_hi_cnt + 1'b1;
         end else if (w_wr_en) begin
            r_lo_cnt <= r_lo_cnt + 1'b1;
         end

         if (!w_drain) begin
            r_rd_cnt <= '0;
            r_hs_cnt <= '0;
         end else begin
            if (w_rd_en) r_rd_cnt <= r_rd_cnt + 1'b1;
            if (w_hs)    r_hs_cnt <= r_hs_cnt + 1'b1;
         end

         r_s1 <= w_rd_en ? 1'b1 : (w_out_load ? 1'b0 : r_s1);
         r_s2 <= w_out_load ? 1'b1 : (w_hs ? 1'b0 : r_s2);
         if (w_out_load) r_out_data <= w_rd_data;
      end
   end

   simple_dual_port_ram_sync #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_buf (
      .clk     (clk),
      .wr_en   (w_wr_en),
      .wr_addr (w_wr_addr),
      .wr_data (bus.in_data),
      .rd_en   (w_rd_en),
      .rd_addr (w_rd_addr),
      .rd_data (w_rd_data)
   );

   assign bus.in_rdy  = w_in_rdy;
   assign bus.hi_vld  = r_s2 && (r_state == ST_DRAIN_HI);
   assign bus.lo_vld  = r_s2 && (r_state == ST_DRAIN_LO);
   assign bus.hi_data = r_out_data;
   assign bus.lo_data = r_out_data;
   assign pkg_num     = r_pkg_num;
   assign pkg_num_vld = r_pkg_num_vld;
   assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_unpackage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_data_unpackage
// Purpose  : Directed self-checking bench for data_unpackage.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_unpackage;

   localparam int DW = 8;
   localparam int AW = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW:0]   pkg_num;
   logic          pkg_num_vld;
   logic          err;

   data_unpackage_if #(.DATA_WIDTH(DW)) bus ();

   data_unpackage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .pkg_num     (pkg_num),
      .pkg_num_vld (pkg_num_vld),
      .err         (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int err_cnt = 0, pkg_cnt = 0, vld_cycles = 0, stall_viol = 0;
   logic [DW-1:0] hi_q[$];
   logic [DW-1:0] lo_q[$];
   int            hs_cyc[$];
   logic          prev_hi_stall = 1'b0, prev_lo_stall = 1'b0;
   logic [DW-1:0] prev_hi_data = '0, prev_lo_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Transfers happen at the next rising edge; inputs only change just after
   // a rising edge, so the falling-edge view is what the DUT will see.
   always @(negedge clk) begin
      if (bus.hi_vld || bus.lo_vld) vld_cycles <= vld_cycles + 1;
      if (bus.hi_vld && bus.hi_rdy) begin
         hi_q.push_back(bus.hi_data);
         hs_cyc.push_back(cyc);
      end
      if (bus.lo_vld && bus.lo_rdy) begin
         lo_q.push_back(bus.lo_data);
         hs_cyc.push_back(cyc);
      end
      if (rst_n && prev_hi_stall && (!bus.hi_vld || bus.hi_data !== prev_hi_data))
         stall_viol <= stall_viol + 1;
      if (rst_n && prev_lo_stall && (!bus.lo_vld || bus.lo_data !== prev_lo_data))
         stall_viol <= stall_viol + 1;
      prev_hi_stall <= bus.hi_vld && !bus.hi_rdy;
      prev_lo_stall <= bus.lo_vld && !bus.lo_rdy;
      prev_hi_data  <= bus.hi_data;
      prev_lo_data  <= bus.lo_data;
      if (err)         err_cnt <= err_cnt + 1;
      if (pkg_num_vld) pkg_cnt <= pkg_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic l);
      int k = 0;
      bus.in_vld  = 1'b1;
      bus.in_data = d;
      bus.in_last = l;
      while (!bus.in_rdy && k < 50) begin
         tick();
         k++;
      end
      if (k >= 50) check("in_rdy_timeout", {31'd0, bus.in_rdy}, 32'd1);
      tick();
   endtask

   task automatic idle();
      bus.in_vld  = 1'b0;
      bus.in_last = 1'b0;
   endtask

   task automatic wait_outs(input string tag, input int n);
      int k = 0;
      while ((hi_q.size() + lo_q.size()) < n && k < 200) begin
         tick();
         k++;
      end
      repeat (3) tick();
      check(tag, hi_q.size() + lo_q.size(), n);
   endtask

   task automatic wait_sig(input string tag, input bit hi);
      int k = 0;
      while (!(hi ? bus.hi_vld : bus.lo_vld) && k < 40) begin
         tick();
         k++;
      end
      check(tag, {31'd0, (hi ? bus.hi_vld : bus.lo_vld)}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int base_err, base_pkg, base_vld;
      bus.in_vld  = 1'b0;
      bus.in_data = '0;
      bus.in_last = 1'b0;
      bus.hi_rdy  = 1'b1;
      bus.lo_rdy  = 1'b1;
      rst_n       = 1'b0;
      repeat (2) tick();

      // reset state
      check("rst_in_rdy",  {31'd0, bus.in_rdy}, 32'd0);
      check("rst_hi_vld",  {31'd0, bus.hi_vld}, 32'd0);
      check("rst_lo_vld",  {31'd0, bus.lo_vld}, 32'd0);
      check("rst_hi_data", {24'd0, bus.hi_data}, 32'd0);
      check("rst_pkg_num", {24'd0, pkg_num}, 32'd0);
      check("rst_pkg_vld", {31'd0, pkg_num_vld}, 32'd0);
      check("rst_err",     {31'd0, err}, 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();
      check("post_rst_in_rdy", {31'd0, bus.in_rdy}, 32'd1);

      // header 3, hi A1 A2 A3, lo 10 11
      send(8'h03, 0); send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0);
      send(8'h10, 0); send(8'h11, 1);
      check("t1_drain_in_rdy", {31'd0, bus.in_rdy}, 32'd0);
      check("t1_pkg_vld",      {31'd0, pkg_num_vld}, 32'd1);
      check("t1_pkg_num",      {24'd0, pkg_num}, 32'd5);
      idle();
      wait_outs("t1_out_count", 5);
      check("t1_hi0", {24'd0, hi_q[0]}, 32'hA1);
      check("t1_hi1", {24'd0, hi_q[1]}, 32'hA2);
      check("t1_hi2", {24'd0, hi_q[2]}, 32'hA3);
      check("t1_lo0", {24'd0, lo_q[0]}, 32'h10);
      check("t1_lo1", {24'd0, lo_q[1]}, 32'h11);
      check("t1_back_to_back", hs_cyc[4] - hs_cyc[0], 32'd4);
      check("t1_pkg_pulses", pkg_cnt, 32'd1);

      // empty frame
      base_pkg = pkg_cnt; base_vld = vld_cycles;
      send(8'h00, 1);
      check("t2_pkg_vld", {31'd0, pkg_num_vld}, 32'd1);
      check("t2_pkg_num", {24'd0, pkg_num}, 32'd0);
      check("t2_in_rdy",  {31'd0, bus.in_rdy}, 32'd1);
      idle();
      repeat (4) tick();
      check("t2_no_valid", vld_cycles - base_vld, 32'd0);
      check("t2_pulses",   pkg_cnt - base_pkg, 32'd1);

      // early in_last in high section
      base_err = err_cnt; base_pkg = pkg_cnt; base_vld = vld_cycles;
      send(8'h04, 0); send(8'hB1, 0); send(8'hB2, 1);
      check("t3_err_pulse", {31'd0, err}, 32'd1);
      idle();
      repeat (4) tick();
      check("t3_err_count", err_cnt - base_err, 32'd1);
      check("t3_no_valid",  vld_cycles - base_vld, 32'd0);
      check("t3_no_pkg",    pkg_cnt - base_pkg, 32'd0);
      hi_q.delete(); lo_q.delete(); hs_cyc.delete();
      send(8'h01, 0); send(8'hC5, 1);
      check("t3_next_pkg_num", {24'd0, pkg_num}, 32'd1);
      idle();
      wait_outs("t3_next_count", 1);
      check("t3_next_hi", {24'd0, hi_q[0]}, 32'hC5);

      // overflow: header 0, 130 low words, err on word 129
      base_err = err_cnt; base_pkg = pkg_cnt; base_vld = vld_cycles;
      send(8'h00, 0);
      for (int i = 1; i <= 130; i++) begin
         send(DW'(i), (i == 130));
         if (i == 128) check("t4_no_err_at_cap", {31'd0, err}, 32'd0);
         if (i == 129) begin
            check("t4_err_word129", {31'd0, err}, 32'd1);
            check("t4_discard_rdy", {31'd0, bus.in_rdy}, 32'd1);
         end
      end
      idle();
      repeat (4) tick();
      check("t4_err_count", err_cnt - base_err, 32'd1);
      check("t4_no_valid",  vld_cycles - base_vld, 32'd0);
      check("t4_no_pkg",    pkg_cnt - base_pkg, 32'd0);

      // hi stall: 55 held while hi_rdy low
      hi_q.delete(); lo_q.delete(); hs_cyc.delete();
      send(8'h02, 0); send(8'h55, 0); send(8'h66, 0); send(8'h77, 1);
      idle();
      wait_sig("t5_hi_vld", 1'b1);
      bus.hi_rdy = 1'b0;
      check("t5_first_data", {24'd0, bus.hi_data}, 32'h55);
      tick();
      check("t5_hold1_vld",  {31'd0, bus.hi_vld}, 32'd1);
      check("t5_hold1_data", {24'd0, bus.hi_data}, 32'h55);
      tick();
      check("t5_hold2_data", {24'd0, bus.hi_data}, 32'h55);
      bus.hi_rdy = 1'b1;
      wait_outs("t5_out_count", 3);
      check("t5_hi0", {24'd0, hi_q[0]}, 32'h55);
      check("t5_hi1", {24'd0, hi_q[1]}, 32'h66);
      check("t5_lo0", {24'd0, lo_q[0]}, 32'h77);
      check("t5_stall_stable", stall_viol, 32'd0);
      check("t5_pkg_num", {24'd0, pkg_num}, 32'd3);

      // reset during DRAIN_LO, then a fresh frame
      hi_q.delete(); lo_q.delete(); hs_cyc.delete();
      bus.lo_rdy = 1'b0;
      send(8'h01, 0); send(8'h05, 0); send(8'h20, 0); send(8'h21, 0); send(8'h22, 1);
      idle();
      wait_sig("t6_lo_vld_pre", 1'b0);
      check("t6_hi_pre", {24'd0, hi_q[0]}, 32'h05);
      rst_n = 1'b0;
      #1;
      check("t6_rst_hi_vld",  {31'd0, bus.hi_vld}, 32'd0);
      check("t6_rst_lo_vld",  {31'd0, bus.lo_vld}, 32'd0);
      check("t6_rst_lo_data", {24'd0, bus.lo_data}, 32'd0);
      check("t6_rst_pkg_num", {24'd0, pkg_num}, 32'd0);
      check("t6_rst_in_rdy",  {31'd0, bus.in_rdy}, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      bus.lo_rdy = 1'b1;
      repeat (2) tick();
      hi_q.delete(); lo_q.delete(); hs_cyc.delete();
      send(8'h01, 0); send(8'h09, 1);
      check("t6_pkg_vld", {31'd0, pkg_num_vld}, 32'd1);
      check("t6_pkg_num", {24'd0, pkg_num}, 32'd1);
      idle();
      wait_outs("t6_out_count", 1);
      check("t6_hi0", {24'd0, hi_q[0]}, 32'h09);
      check("t6_lo_none", lo_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_unpackage.md
DATA_UNPACKAGE -- requirements
Module: data_unpackage

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte/word width of all data ports.
REQ-002 Parameter ADDR_WIDTH, default 7, buffer address width; capacity CAP = 2^ADDR_WIDTH words.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_vld  input  1  input word valid.
REQ-006 in_data  input  DATA_WIDTH  frame word (header or payload).
REQ-007 in_last  input  1  marks the final word of a frame.
REQ-008 in_rdy  output  1  block accepts an input word; transfer when in_vld & in_rdy.
REQ-009 hi_vld / hi_data / hi_rdy  output / output / input  1 / DATA_WIDTH / 1  high-type output channel.
REQ-010 lo_vld / lo_data / lo_rdy  output / output / input  1 / DATA_WIDTH / 1  low-type output channel.
REQ-011 pkg_num  output  ADDR_WIDTH+1  payload word count of the last accepted frame.
REQ-012 pkg_num_vld  output  1  one-cycle pulse qualifying pkg_num.
REQ-013 err  output  1  one-cycle pulse on frame rejection.

Function
REQ-014 Frame format: header word (H = in_data[ADDR_WIDTH-1:0], high-word count), then H high words, then zero or more low words; in_last on the final word.
REQ-015 FSM states: IDLE, RX_HI, RX_LO, DISCARD, DRAIN_HI, DRAIN_LO.
REQ-016 IDLE: in_rdy=1; header accepted -> RX_HI if H>0, else RX_LO; header with in_last and H=0 -> empty frame, pkg_num=0 pulse, stay IDLE; header with in_last and H>0 -> err, stay IDLE.
REQ-017 RX_HI: in_rdy=1; k-th high word (k=0..H-1) written at address CAP-1-k; after H-th word -> RX_LO, or -> DRAIN_HI if it carries in_last.
REQ-018 RX_HI: in_last before H-th word -> err pulse, frame dropped, -> IDLE.
REQ-019 RX_LO: in_rdy=1; j-th low word written at address j; word with in_last -> DRAIN_HI (or DRAIN_LO if H=0).
REQ-020 Overflow: accepting a word when H+L already equals CAP -> err pulse, word dropped, -> DISCARD (or IDLE if that word has in_last).
REQ-021 DISCARD: in_rdy=1, words consumed and ignored until in_last -> IDLE.
REQ-022 On entry to DRAIN_HI/DRAIN_LO, pkg_num = H+L and pkg_num_vld pulses exactly one cycle.
REQ-023 DRAIN states: in_rdy=0; no output valid before the whole frame is accepted (frame-atomic).
REQ-024 DRAIN_HI: high words presented on hi channel in arrival order (addresses CAP-1 down to CAP-H); lo_vld=0; after last hi handshake -> DRAIN_LO, or IDLE if L=0.
REQ-025 DRAIN_LO: low words on lo channel in arrival order (addresses 0 up to L-1); hi_vld=0; after last lo handshake -> IDLE.
REQ-026 Buffer read latency 1 cycle; output register holds data; next read issued when output register empty or handshake occurring, giving one word per cycle under continuous ready.
REQ-027 hi_data/lo_data stable while vld=1 and rdy=0; vld never deasserts without handshake.
REQ-028 First output valid no later than 2 cycles after DRAIN entry.
REQ-029 Address counters wrap modulo CAP only via REQ-020 check; no silent overwrite.

Reset
REQ-030 rst_n low: FSM -> IDLE, counters 0, in_rdy=0 during reset then 1, hi_vld=lo_vld=0, hi_data=lo_data=0, pkg_num=0, pkg_num_vld=0, err=0.
REQ-031 Reset mid-frame or mid-drain discards all buffered data; first frame after release is handled normally.

Structure
REQ-032 FSM state encodings and default widths reside in shared package/header data_package_pkg used by packer and unpacker.
REQ-033 Storage instantiates existing sub-module simple_dual_port_ram_sync (DATA_WIDTH, ADDR_WIDTH), write port driven by RX, read port by DRAIN.

Verification
REQ-034 Header 3, hi A1 A2 A3, lo 10 11 (last), both rdy=1 -> pkg_num=5 pulse, hi A1 A2 A3 then lo 10 11, back-to-back.
REQ-035 Header 0 + in_last -> pkg_num=0 pulse, no hi/lo valid, in_rdy stays 1.
REQ-036 Header 4, two hi words with in_last on second -> err pulse, no outputs, next frame accepted.
REQ-037 Header 0, 129 low words at ADDR_WIDTH=7 -> err on word 129, DISCARD to in_last, no outputs.
REQ-038 Header 2, hi 55 66, lo 77 (last), hi_rdy toggled 1-0-0-1 -> hi_data 55 held while stalled, order 55 66 77 preserved.
REQ-039 rst_n asserted during DRAIN_LO -> all valids 0 immediately; fresh frame header 1, hi 9 (last) -> hi 9 output, pkg_num=1.
